// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request handshake, IF/ID output register
// with one-entry skid buffer, branch redirect/squash and HLT-driven stop.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        halted
);

    localparam int unsigned XLEN = 16;
    localparam int unsigned OPW  = 4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            active;
    logic            squash;
    logic [XLEN-1:0] squash_addr;
    logic            skid_valid;
    entry_t          skid;

    logic            redirect_take;
    logic            resp_ok;
    logic            resp_hlt;
    logic            load_out;
    logic            consume_hlt;
    entry_t          resp;

    // A squashed request keeps its original address until memory answers it.
    assign imem_req  = active && !halted &&
                       (squash || (state == WAIT) || ((state == RUN) && !skid_valid));
    assign imem_addr = squash ? squash_addr : pc;

    always_comb begin
        redirect_take = redirect && !halted;
        resp_ok       = imem_req && imem_ready && !squash && !redirect_take;
        resp_hlt      = (imem_data[XLEN-1 -: OPW] == HLT_OPCODE);
        load_out      = !if_valid || !stall;
        consume_hlt   = if_valid && !stall && !redirect &&
                        (if_instr[XLEN-1 -: OPW] == HLT_OPCODE);
        resp.instr    = imem_data;
        resp.pc       = pc;
    end

    // State register, PC, skid buffer and IF/ID output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            active      <= 1'b0;
            squash      <= 1'b0;
            squash_addr <= '0;
            skid_valid  <= 1'b0;
            skid        <= '0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus2 <= '0;
            halted      <= 1'b0;
        end else begin
            active <= 1'b1;
            if (consume_hlt) begin
                halted <= 1'b1;
            end

            if (redirect_take) begin
                pc          <= redirect_pc;
                state       <= RUN;
                if_valid    <= 1'b0;
                skid_valid  <= 1'b0;
                squash      <= imem_req && !imem_ready;
                squash_addr <= imem_addr;
            end else begin
                if (squash && imem_ready) begin
                    squash <= 1'b0;
                end

                case (state)
                    RUN: begin
                        if (resp_ok) begin
                            state <= resp_hlt ? HALT : RUN;
                        end else if (imem_req && !squash && !imem_ready) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (resp_ok) begin
                            state <= resp_hlt ? HALT : RUN;
                        end
                    end
                    HALT: state <= HALT;
                    default: state <= RUN;
                endcase

                // PC stops on the HLT so a later redirect is the only way forward.
                if (resp_ok && !resp_hlt) begin
                    pc <= pc + XLEN'(2);
                end

                if (load_out) begin
                    if (skid_valid) begin
                        if_valid    <= 1'b1;
                        if_instr    <= skid.instr;
                        if_pc       <= skid.pc;
                        if_pc_plus2 <= skid.pc + XLEN'(2);
                        skid_valid  <= resp_ok;
                        skid        <= resp;
                    end else if (resp_ok) begin
                        if_valid    <= 1'b1;
                        if_instr    <= resp.instr;
                        if_pc       <= resp.pc;
                        if_pc_plus2 <= resp.pc + XLEN'(2);
                    end else begin
                        if_valid    <= 1'b0;
                    end
                end else if (resp_ok) begin
                    skid_valid <= 1'b1;
                    skid       <= resp;
                end
            end
        end
    end

    // Issue is blocked while the skid is full, so a response can never overflow it.
    a_skid_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(resp_ok && skid_valid && !load_out));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, wait states, stall/skid, redirect,
// HLT, PC wrap and asynchronous reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        halted;
    logic        hlt_on;

    logic        w_imem_req;
    logic [15:0] w_imem_addr;
    logic        w_imem_ready;
    logic [15:0] w_imem_data;
    logic        w_stall;
    logic        w_redirect;
    logic [15:0] w_redirect_pc;
    logic        w_if_valid;
    logic [15:0] w_if_instr;
    logic [15:0] w_if_pc;
    logic [15:0] w_if_pc_plus2;
    logic        w_halted;

    int checks = 0;
    int errors = 0;

    // Instruction memory image: mostly {1, addr[11:0]}, a few fixed words.
    assign imem_data = (hlt_on && imem_addr == 16'h0006) ? 16'hF000 :
                       (imem_addr == 16'h0008) ? 16'h1234 :
                       (imem_addr == 16'h000A) ? 16'h5678 :
                       {4'h1, imem_addr[11:0]};
    assign w_imem_data = {4'h2, w_imem_addr[11:0]};

    fetch_stage #(.RESET_PC(16'h0000), .HLT_OPCODE(4'b1111)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus2(if_pc_plus2), .halted(halted)
    );

    fetch_stage #(.RESET_PC(16'hFFFE), .HLT_OPCODE(4'b1111)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ready(w_imem_ready), .imem_data(w_imem_data),
        .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc),
        .if_pc_plus2(w_if_pc_plus2), .halted(w_halted)
    );

    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        imem_ready = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        hlt_on = 1'b0;
        w_imem_ready = 1'b1;
        w_stall = 1'b0;
        w_redirect = 1'b0;
        w_redirect_pc = 16'h0000;

        // Reset state
        #3;
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", if_valid, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk16("rst_pc", if_pc, 16'h0000);
        chk1("w_rst_req", w_imem_req, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        chk1("req_before_edge", imem_req, 1'b0);
        step();
        chk1("first_req", imem_req, 1'b1);
        chk16("first_addr", imem_addr, 16'h0000);
        chk1("first_valid", if_valid, 1'b0);
        chk16("w_first_addr", w_imem_addr, 16'hFFFE);

        // Zero-wait stream
        step();
        chk1("s0_valid", if_valid, 1'b1);
        chk16("s0_pc", if_pc, 16'h0000);
        chk16("s0_pc2", if_pc_plus2, 16'h0002);
        chk16("s0_instr", if_instr, 16'h1000);
        chk16("w_s0_pc", w_if_pc, 16'hFFFE);
        chk16("w_s0_pc2", w_if_pc_plus2, 16'h0000);
        chk16("w_wrap_addr", w_imem_addr, 16'h0000);
        step();
        chk16("s1_pc", if_pc, 16'h0002);
        chk16("s1_pc2", if_pc_plus2, 16'h0004);
        chk16("w_s1_pc", w_if_pc, 16'h0000);

        // Wait states on 0x0004
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1("ws_req", imem_req, 1'b1);
            chk16("ws_addr", imem_addr, 16'h0004);
            step();
        end
        chk1("ws_valid_low", if_valid, 1'b0);
        chk16("ws_addr_held", imem_addr, 16'h0004);
        imem_ready = 1'b1;
        step();
        chk1("ws_valid", if_valid, 1'b1);
        chk16("ws_pc", if_pc, 16'h0004);
        chk16("ws_pc2", if_pc_plus2, 16'h0006);
        chk16("ws_instr", if_instr, 16'h1004);
        step();
        chk16("ws_nodup", if_pc, 16'h0006);
        step();
        chk16("st_pre_instr", if_instr, 16'h1234);
        chk16("st_pre_pc", if_pc, 16'h0008);

        // Stall with skid capture
        stall = 1'b1;
        step();
        chk16("st1_instr", if_instr, 16'h1234);
        chk16("st1_pc", if_pc, 16'h0008);
        chk1("st1_req", imem_req, 1'b0);
        step();
        chk16("st2_instr", if_instr, 16'h1234);
        chk1("st2_req", imem_req, 1'b0);
        stall = 1'b0;
        step();
        chk16("st_rel_instr", if_instr, 16'h5678);
        chk16("st_rel_pc", if_pc, 16'h000A);
        chk1("st_rel_req", imem_req, 1'b1);
        chk16("st_rel_addr", imem_addr, 16'h000C);
        step();
        chk16("st_next_pc", if_pc, 16'h000C);
        step();
        chk16("pre_rd_pc", if_pc, 16'h000E);
        chk16("pre_rd_addr", imem_addr, 16'h0010);

        // Redirect during WAIT
        imem_ready = 1'b0;
        step();
        step();
        chk1("rd_wait_req", imem_req, 1'b1);
        chk16("rd_wait_addr", imem_addr, 16'h0010);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        chk1("rd_flush_valid", if_valid, 1'b0);
        chk16("rd_old_addr", imem_addr, 16'h0010);
        chk1("rd_old_req", imem_req, 1'b1);
        imem_ready = 1'b1;
        step();
        chk1("rd_discard_valid", if_valid, 1'b0);
        chk16("rd_new_addr", imem_addr, 16'h0040);
        step();
        chk1("rd_tgt_valid", if_valid, 1'b1);
        chk16("rd_tgt_pc", if_pc, 16'h0040);
        chk16("rd_tgt_instr", if_instr, 16'h1040);

        // Redirect together with stall
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0080;
        step();
        stall = 1'b0;
        redirect = 1'b0;
        chk1("rs_valid", if_valid, 1'b0);
        chk16("rs_addr", imem_addr, 16'h0080);
        step();
        chk16("rs_pc", if_pc, 16'h0080);

        // HLT at 0x0006
        hlt_on = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0006;
        step();
        redirect = 1'b0;
        chk16("h_addr", imem_addr, 16'h0006);
        step();
        chk16("h_instr", if_instr, 16'hF000);
        chk16("h_pc", if_pc, 16'h0006);
        chk1("h_req_off", imem_req, 1'b0);
        chk1("h_not_yet", halted, 1'b0);
        step();
        chk1("h_halted", halted, 1'b1);
        chk1("h_valid", if_valid, 1'b0);
        redirect = 1'b1;
        redirect_pc = 16'h0020;
        step();
        redirect = 1'b0;
        chk1("h_rd_ignored_req", imem_req, 1'b0);
        chk1("h_sticky", halted, 1'b1);
        step();
        chk1("h_still_off", imem_req, 1'b0);

        // Reset, then redirect away from a pending HLT
        rst_n = 1'b0;
        #1;
        chk1("r2_halted", halted, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk16("r2_addr", imem_addr, 16'h0000);
        redirect = 1'b1;
        redirect_pc = 16'h0006;
        step();
        redirect = 1'b0;
        chk1("v_valid0", if_valid, 1'b0);
        step();
        chk16("v_hlt_instr", if_instr, 16'hF000);
        redirect = 1'b1;
        redirect_pc = 16'h0020;
        step();
        redirect = 1'b0;
        chk1("v_no_halt", halted, 1'b0);
        chk1("v_req", imem_req, 1'b1);
        chk16("v_addr", imem_addr, 16'h0020);
        step();
        chk16("v_pc", if_pc, 16'h0020);
        chk16("v_instr", if_instr, 16'h1020);
        chk1("v_no_halt2", halted, 1'b0);

        // Asynchronous reset in the middle of a WAIT
        stall = 1'b1;
        imem_ready = 1'b0;
        step();
        chk1("ar_valid_pre", if_valid, 1'b1);
        chk1("ar_req_pre", imem_req, 1'b1);
        chk16("ar_addr_pre", imem_addr, 16'h0022);
        rst_n = 1'b0;
        #1;
        chk1("ar_valid", if_valid, 1'b0);
        chk1("ar_req", imem_req, 1'b0);
        stall = 1'b0;
        imem_ready = 1'b1;
        step();
        rst_n = 1'b1;
        chk1("ar_req_rel", imem_req, 1'b0);
        step();
        chk1("ar_refetch_req", imem_req, 1'b1);
        chk16("ar_refetch_addr", imem_addr, 16'h0000);
        step();
        chk16("ar_refetch_pc", if_pc, 16'h0000);
        chk1("ar_refetch_valid", if_valid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
